// File: rtl/unpooling.sv
// 2x2 nearest-neighbour upsampler: each pooled pixel is emitted twice live, then the
// buffered row is replayed once more to form the lower output row.
module unpooling #(
    parameter int DATA_W  = 16,
    parameter int IN_COLS = 12,
    parameter int IN_ROWS = 10
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              valid_in,
    output logic              in_ready,
    output logic [DATA_W-1:0] result,
    output logic              valid_out,
    output logic              frame_done,
    output logic              overflow
);

    localparam int COL_W = $clog2(IN_COLS + 1);
    localparam int ROW_W = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
    localparam int IDX_W = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
    localparam int REP_W = IDX_W + 1;

    typedef enum logic [1:0] {TOP, DUP, REPLAY} state_t;

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              valid_out_q, valid_out_d;
    logic              frame_done_q, frame_done_d;
    logic              overflow_q, overflow_d;
    logic              in_ready_q, in_ready_d;

    logic [DATA_W-1:0] line_mem [IN_COLS];
    logic              accept;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    assign accept = valid_in && in_ready_q;
    assign wr_idx = col_q[IDX_W-1:0];
    // Each buffered pixel is replayed on two consecutive cycles.
    assign rd_idx = rep_q[REP_W-1:1];

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        rep_d        = rep_q;
        result_d     = result_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        in_ready_d   = in_ready_q;
        overflow_d   = overflow_q | (valid_in & ~in_ready_q);
        case (state_q)
            TOP: begin
                if (accept) begin
                    result_d    = s_data;
                    valid_out_d = 1'b1;
                    col_d       = col_q + COL_W'(1);
                    in_ready_d  = 1'b0;
                    state_d     = DUP;
                end
            end
            DUP: begin
                valid_out_d = 1'b1;
                if (col_q != COL_W'(IN_COLS)) begin
                    in_ready_d = 1'b1;
                    state_d    = TOP;
                end else begin
                    rep_d   = '0;
                    state_d = REPLAY;
                end
            end
            REPLAY: begin
                valid_out_d = 1'b1;
                result_d    = line_mem[rd_idx];
                rep_d       = rep_q + REP_W'(1);
                // Reopen the input on the final replay word so the next row follows gap-free.
                if (rep_q == REP_W'(2 * IN_COLS - 1)) begin
                    in_ready_d = 1'b1;
                    col_d      = '0;
                    state_d    = TOP;
                    if (row_q == ROW_W'(IN_ROWS - 1)) begin
                        row_d        = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            default: state_d = TOP;
        endcase
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= TOP;
            col_q        <= '0;
            row_q        <= '0;
            rep_q        <= '0;
            result_q     <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            rep_q        <= rep_d;
            result_q     <= result_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // Row storage is deliberately unreset; entries are always written before replay.
    always_ff @(posedge clk) begin
        if (state_q == TOP && accept) begin
            line_mem[wr_idx] <= s_data;
        end
    end

    assign in_ready   = in_ready_q;
    assign result     = result_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_unpooling.sv
// Directed bench for unpooling: vector table, row timing, overflow, mid-frame reset, full frames.
module tb_unpooling;

    localparam int DATA_W        = 16;
    localparam int IN_COLS       = 12;
    localparam int IN_ROWS       = 10;
    localparam int OUT_PER_FRAME = 4 * IN_COLS * IN_ROWS;

    logic              clk = 1'b0;
    logic              Rst = 1'b1;
    logic [DATA_W-1:0] s_data = '0;
    logic              valid_in = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] result;
    logic              valid_out;
    logic              frame_done;
    logic              overflow;

    unpooling #(.DATA_W(DATA_W), .IN_COLS(IN_COLS), .IN_ROWS(IN_ROWS)) dut (
        .clk(clk), .Rst(Rst), .s_data(s_data), .valid_in(valid_in),
        .in_ready(in_ready), .result(result), .valid_out(valid_out),
        .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit collect = 1'b0;
    logic [DATA_W-1:0] mon_dat[$];
    logic              mon_fd[$];

    typedef struct {
        logic              vin;
        logic [DATA_W-1:0] din;
        logic              vout;
        logic [DATA_W-1:0] res;
        logic              rdy;
        logic              ovf;
    } vec_t;
    vec_t tbl[11];

    int u, r, ja;
    logic [DATA_W-1:0] expv;

    always @(negedge clk) begin
        if (collect && valid_out) begin
            mon_dat.push_back(result);
            mon_fd.push_back(frame_done);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic apply_reset();
        Rst = 1'b1;
        valid_in = 1'b0;
        s_data = '0;
        repeat (4) @(negedge clk);
        chk("rst_vout", valid_out, 0);
        chk("rst_res", result, 0);
        chk("rst_rdy", in_ready, 1);
        chk("rst_ovf", overflow, 0);
        chk("rst_fd", frame_done, 0);
        Rst = 1'b0;
        @(negedge clk);
        chk("post_rst_vout", valid_out, 0);
        chk("post_rst_res", result, 0);
        chk("post_rst_rdy", in_ready, 1);
    endtask

    task automatic send_pixel(input logic [DATA_W-1:0] v, input int gap);
        int n = 0;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", in_ready, 1);
        valid_in = 1'b1;
        s_data = v;
        @(negedge clk);
        valid_in = 1'b0;
        s_data = '0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic run_frame(input string nm);
        int bad = 0;
        int fds = 0;
        int fd_idx = -1;
        mon_dat.delete();
        mon_fd.delete();
        collect = 1'b1;
        for (int v = 0; v < IN_COLS * IN_ROWS; v++)
            send_pixel(DATA_W'(v), int'($urandom_range(1, 3)));
        repeat (30) @(negedge clk);
        collect = 1'b0;
        for (int i = 0; i < mon_dat.size(); i++) begin
            int rr = i / (4 * IN_COLS);
            int cc = (i % (2 * IN_COLS)) / 2;
            logic [DATA_W-1:0] e = DATA_W'(rr * IN_COLS + cc);
            if (mon_dat[i] !== e) bad++;
            if (mon_fd[i]) begin
                fds++;
                fd_idx = i;
            end
        end
        chk({nm, "_count"}, mon_dat.size(), OUT_PER_FRAME);
        chk({nm, "_data_errors"}, bad, 0);
        chk({nm, "_fd_count"}, fds, 1);
        chk({nm, "_fd_pos"}, fd_idx, OUT_PER_FRAME - 1);
    endtask

    initial begin
        // vin, din, expected vout, result, in_ready, overflow after the edge
        tbl[0]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 16'h0005, 1'b1, 16'h0005, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 16'h0006, 1'b1, 16'h0005, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 16'h0000, 1'b0, 16'h0005, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 16'h0007, 1'b1, 16'h0007, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 16'h0000, 1'b1, 16'h0007, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 16'h0007, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 16'hffff, 1'b1, 16'hffff, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 16'h1234, 1'b1, 16'hffff, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 16'h1234, 1'b1, 16'h1234, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 16'h0000, 1'b1, 16'h1234, 1'b1, 1'b1};

        apply_reset();
        for (int i = 0; i < 11; i++) begin
            valid_in = tbl[i].vin;
            s_data = tbl[i].din;
            @(negedge clk);
            chk($sformatf("vec%0d_vout", i), valid_out, tbl[i].vout);
            chk($sformatf("vec%0d_res", i), result, tbl[i].res);
            chk($sformatf("vec%0d_rdy", i), in_ready, tbl[i].rdy);
            chk($sformatf("vec%0d_ovf", i), overflow, tbl[i].ovf);
        end
        valid_in = 1'b0;

        // Row 0 paced every other cycle; row 1 with valid_in held high throughout.
        apply_reset();
        for (int t = 0; t < 96; t++) begin
            u = t % 48;
            r = t / 48;
            if (r == 0) begin
                valid_in = (u < 24) && (u % 2 == 0);
                s_data = DATA_W'(u / 2 + 1);
            end else begin
                valid_in = 1'b1;
                s_data = DATA_W'(100 + t);
            end
            @(negedge clk);
            ja = (u < 24) ? u / 2 : (u - 24) / 2;
            expv = (r == 0) ? DATA_W'(ja + 1) : DATA_W'(148 + 2 * ja);
            chk($sformatf("row_vout_t%0d", t), valid_out, 1);
            chk($sformatf("row_data_t%0d", t), result, expv);
            chk($sformatf("row_rdy_t%0d", t), in_ready, (u < 22) ? (u % 2) : (u == 47 ? 1 : 0));
            chk($sformatf("row_ovf_t%0d", t), overflow, (r == 1 && u >= 1) ? 1 : 0);
            chk($sformatf("row_fd_t%0d", t), frame_done, 0);
        end
        valid_in = 1'b0;
        s_data = '0;

        // Abandon a frame mid-row with an asynchronous reset pulse.
        apply_reset();
        for (int i = 0; i < 3 * IN_COLS + 7; i++)
            send_pixel(DATA_W'(500 + i), (i == 3 * IN_COLS + 6) ? 0 : 1);
        chk("pre_abandon_vout", valid_out, 1);
        chk("pre_abandon_res", result, 500 + 3 * IN_COLS + 6);
        #2 Rst = 1'b1;
        #1;
        chk("abandon_vout", valid_out, 0);
        chk("abandon_res", result, 0);
        chk("abandon_rdy", in_ready, 1);
        chk("abandon_fd", frame_done, 0);
        @(negedge clk);
        Rst = 1'b0;
        @(negedge clk);

        run_frame("frame_a");
        run_frame("frame_b");
        chk("final_ovf", overflow, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unpooling.md
UNPOOLING -- requirements
Module: unpooling

Interface
REQ-001 Parameters (name, default, meaning): DATA_W, 16, pixel width; IN_COLS, 12, pooled pixels per row; IN_ROWS, 10, pooled rows per frame.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 Rst  input  1  reset, asynchronous, active-high.
REQ-004 s_data  input  DATA_W  pooled pixel in, row-major.
REQ-005 valid_in  input  1  s_data valid this cycle; no hold requirement on source.
REQ-006 in_ready  output  1  registered; block can accept s_data this cycle.
REQ-007 result  output  DATA_W  registered upsampled pixel out.
REQ-008 valid_out  output  1  registered; result valid; no backpressure on output.
REQ-009 frame_done  output  1  registered one-cycle pulse with last pixel of a frame.
REQ-010 overflow  output  1  sticky flag: input offered while in_ready low.

Function
REQ-011 Block performs 2x2 nearest-neighbour upsampling: IN_COLS x IN_ROWS in -> 2*IN_COLS x 2*IN_ROWS out, row-major, 4*IN_COLS*IN_ROWS outputs per frame (480 at defaults).
REQ-012 Accept = valid_in && in_ready sampled at a rising edge; accepted word written to line buffer entry col (IN_COLS x DATA_W) and col incremented.
REQ-013 States: TOP (emit upper output row live), DUP (emit duplicate of just-accepted pixel), REPLAY (emit lower output row from line buffer).
REQ-014 TOP: on accept at edge k, result=s_data with valid_out=1 after edge k; go DUP, in_ready=0 after edge k.
REQ-015 DUP: after edge k+1 result repeats same pixel, valid_out=1; if col != IN_COLS then TOP with in_ready=1, else REPLAY with in_ready=0.
REQ-016 TOP with no accept: valid_out=0, result holds last value.
REQ-017 REPLAY: 2*IN_COLS consecutive cycles valid_out=1, result = buf[0],buf[0],buf[1],buf[1],...,buf[IN_COLS-1],buf[IN_COLS-1]; first replay word after edge k+2 (k = last-column accept), so valid_out high contiguously for 2*IN_COLS+2 cycles from last-column output.
REQ-018 in_ready reasserted on the edge issuing the final replay word; next accept may occur on the following edge with no output gap or collision.
REQ-019 After REPLAY: col=0, row incremented; at row IN_ROWS-1 frame_done=1 coincident with final replay word, row wraps to 0; frame_done 0 otherwise.
REQ-020 Maximum input rate one accept per 2 cycles; arbitrary gaps between inputs allowed in TOP.
REQ-021 valid_in while in_ready=0 (DUP or REPLAY): word dropped, no state/buffer/output change, overflow set to 1 and held until reset.
REQ-022 Data passes unmodified; no arithmetic on pixel values; col/row counters sized ceil(log2(IN_COLS+1)), ceil(log2(IN_ROWS)).

Reset
REQ-023 Rst=1 asynchronously forces: state TOP, col=0, row=0, result=0, valid_out=0, frame_done=0, overflow=0, in_ready=1.
REQ-024 Line buffer contents not reset; never read before being written in current row.
REQ-025 Rst mid-row or mid-REPLAY abandons partial row/frame; first accept after release is pixel (0,0) of a new frame.

Verification
REQ-026 Hold Rst=1 for 40 ns, release -> result=0, valid_out=0, frame_done=0, overflow=0, in_ready=1 until first accept.
REQ-027 Row test: s_data 1..12, one every 2 cycles -> result 1,1,2,2,...,12,12 contiguous, then replay 1,1,...,12,12 for 24 cycles; valid_out high 48 consecutive cycles from 23rd output onward-contiguous block of 26; in_ready low 25 cycles after 12th accept.
REQ-028 Full frame: s_data 0..119 with random gaps (>=1 idle per accept) -> exactly 480 valid_out, each value v appearing 4 times at 2x2 positions; frame_done exactly once, on the 480th output; second frame identical.
REQ-029 Back-to-back valid_in with s_data 5,6 -> 5 emitted twice, 6 dropped, overflow=1 and stays 1; next accepted word emitted normally.
REQ-030 valid_in asserted throughout REPLAY -> all dropped, replay sequence unaltered, overflow=1.
REQ-031 Rst pulse after 7th accept of row 3 -> outputs cleared immediately; subsequent 120 inputs produce a complete 480-output frame with one frame_done.
